// File: rtl/hd_sample_feeder_if.sv
// hd_sample_feeder_if
//   Groups the feature stream and the HDC core control signals of the sample
//   feeder into one bundle.
//   master : upstream source / core side (drives the feature stream, observes
//            the core controls)
//   slave  : the feeder itself (accepts features, drives the core controls)
// Signals
//   in_valid/in_ready/in_value/in_last  feature beat handshake and payload
//   in_mode/in_label                    sampled on a sample's first beat
//   in_setlast                          sampled on the closing beat
//   state/smp_en/im_value/im_pos        per-feature core drive
//   smp_clr/label/set_clr               sample and set framing
//   pred_valid                          predict result strobe
//   err_len                             sticky over-length flag
interface hd_sample_feeder_if #(
  parameter int DIM    = 1024,
  parameter int VAL_W  = 8,
  parameter int CLS_DW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [VAL_W-1:0]  in_value;
  logic              in_last;
  logic              in_mode;
  logic [CLS_DW-1:0] in_label;
  logic              in_setlast;
  logic              state;
  logic              smp_en;
  logic [DIM-1:0]    im_value;
  logic [DIM-1:0]    im_pos;
  logic              smp_clr;
  logic [CLS_DW-1:0] label;
  logic              set_clr;
  logic              pred_valid;
  logic              err_len;

  modport master (
    output in_valid, in_value, in_last, in_mode, in_label, in_setlast,
    input  in_ready, state, smp_en, im_value, im_pos, smp_clr, label,
           set_clr, pred_valid, err_len
  );

  modport slave (
    input  in_valid, in_value, in_last, in_mode, in_label, in_setlast,
    output in_ready, state, smp_en, im_value, im_pos, smp_clr, label,
           set_clr, pred_valid, err_len
  );
endinterface

// File: rtl/hd_sample_feeder.sv
// hd_sample_feeder
//   Upstream sequencer for the HDC classifier core. Each accepted feature beat
//   becomes one smp_en pulse carrying a level hypervector (derived from the
//   top bits of the feature value) and a position hypervector (a seed rotated
//   left by the feature index). Samples are framed with smp_clr, training sets
//   with set_clr, and in predict mode the core's result latency is timed so a
//   single pred_valid strobe marks the valid output.
// Ports
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    hd_sample_feeder_if.slave: feature stream in, core controls out
//          (all outputs are registered)
// Mode encoding: 0 = train, 1 = predict.
module hd_sample_feeder #(
  parameter int             DIM      = 1024,
  parameter int             VAL_W    = 8,
  parameter int             LVL_NUM  = 16,
  parameter int             FEAT_MAX = 784,
  parameter int             CLS_DW   = 4,
  parameter int             PRED_LAT = 2,
  parameter logic [DIM-1:0] POS_SEED = {{(DIM-1){1'b0}}, 1'b1},
  parameter logic [DIM-1:0] LVL_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  hd_sample_feeder_if.slave bus
);

  localparam logic MODE_TRAIN   = 1'b0;
  localparam logic MODE_PREDICT = 1'b1;

  localparam int LW   = $clog2(LVL_NUM);
  localparam int STEP = DIM / LVL_NUM;
  localparam int TW   = $clog2(DIM + 1);
  localparam int CW   = $clog2(FEAT_MAX + 1);
  localparam int WW   = $clog2(PRED_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_CLOSE,
    S_SETCLR,
    S_WAIT
  } fsm_t;

  fsm_t              fsm_reg;
  logic              in_ready_reg;
  logic              state_reg;
  logic              smp_en_reg;
  logic [DIM-1:0]    im_value_reg;
  logic [DIM-1:0]    im_pos_reg;
  logic              smp_clr_reg;
  logic [CLS_DW-1:0] label_reg;
  logic              set_clr_reg;
  logic              pred_valid_reg;
  logic              err_len_reg;
  logic [DIM-1:0]    pos_reg;
  logic [CW-1:0]     cnt_reg;
  logic              setlast_reg;
  logic [WW-1:0]     wait_reg;

  logic              accept;
  logic              cnt_at_max;
  logic [LW-1:0]     lvl;
  logic [TW-1:0]     lvl_thresh;
  logic [DIM-1:0]    lvl_vec;

  assign accept     = bus.in_valid & in_ready_reg;
  assign cnt_at_max = (cnt_reg == CW'(FEAT_MAX - 1));

  // Quantization keeps only the top LW bits of the feature value.
  assign lvl        = bus.in_value[VAL_W-1 -: LW];
  assign lvl_thresh = TW'(lvl) * TW'(STEP);

  // Level vector: the lowest lvl*STEP bits of the seed are flipped, so the
  // Hamming distance between levels grows linearly with the level index.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lvl_bit
      assign lvl_vec[gi] = LVL_SEED[gi] ^ (lvl_thresh > TW'(gi));
    end
    if (VAL_W > LW) begin : g_low_bits
      // Sub-level resolution of the feature value is intentionally discarded.
      logic unused_low_bits;
      assign unused_low_bits = ^bus.in_value[VAL_W-LW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg        <= S_IDLE;
      in_ready_reg   <= 1'b1;
      state_reg      <= MODE_TRAIN;
      smp_en_reg     <= 1'b0;
      im_value_reg   <= '0;
      im_pos_reg     <= '0;
      smp_clr_reg    <= 1'b0;
      label_reg      <= '0;
      set_clr_reg    <= 1'b0;
      pred_valid_reg <= 1'b0;
      err_len_reg    <= 1'b0;
      pos_reg        <= POS_SEED;
      cnt_reg        <= '0;
      setlast_reg    <= 1'b0;
      wait_reg       <= '0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them.
      smp_en_reg     <= 1'b0;
      smp_clr_reg    <= 1'b0;
      set_clr_reg    <= 1'b0;
      pred_valid_reg <= 1'b0;

      case (fsm_reg)
        S_IDLE, S_FEED: begin
          if (accept) begin
            // Mode and label belong to the whole sample: only the first beat
            // may change them, which keeps state stable through smp_clr.
            if (fsm_reg == S_IDLE) begin
              state_reg <= bus.in_mode;
              label_reg <= (bus.in_mode == MODE_PREDICT) ? '0 : bus.in_label;
            end
            smp_en_reg   <= 1'b1;
            im_value_reg <= lvl_vec;
            im_pos_reg   <= pos_reg;
            pos_reg      <= {pos_reg[DIM-2:0], pos_reg[DIM-1]};
            cnt_reg      <= cnt_reg + CW'(1);
            if (bus.in_last || cnt_at_max) begin
              fsm_reg      <= S_CLOSE;
              in_ready_reg <= 1'b0;
              setlast_reg  <= bus.in_setlast;
              if (!bus.in_last) begin
                err_len_reg <= 1'b1;
              end
            end else begin
              fsm_reg <= S_FEED;
            end
          end
        end

        S_CLOSE: begin
          smp_clr_reg <= 1'b1;
          cnt_reg     <= '0;
          pos_reg     <= POS_SEED;
          wait_reg    <= '0;
          if (state_reg == MODE_TRAIN && setlast_reg) begin
            fsm_reg <= S_SETCLR;
          end else if (state_reg == MODE_PREDICT) begin
            fsm_reg <= S_WAIT;
          end else begin
            fsm_reg      <= S_IDLE;
            in_ready_reg <= 1'b1;
          end
        end

        // SETCLR spans the smp_clr cycle and the set_clr cycle; the stream
        // reopens only once set_clr has been seen by the core.
        S_SETCLR: begin
          if (set_clr_reg) begin
            fsm_reg      <= S_IDLE;
            in_ready_reg <= 1'b1;
          end else begin
            set_clr_reg <= 1'b1;
          end
        end

        // wait_reg counts cycles since the smp_clr cycle; pred_valid lands
        // PRED_LAT cycles after smp_clr and the stream reopens after it.
        S_WAIT: begin
          if (pred_valid_reg) begin
            fsm_reg      <= S_IDLE;
            in_ready_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + WW'(1);
            if (wait_reg == WW'(PRED_LAT - 1)) begin
              pred_valid_reg <= 1'b1;
            end
          end
        end

        default: begin
          fsm_reg      <= S_IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.state      = state_reg;
  assign bus.smp_en     = smp_en_reg;
  assign bus.im_value   = im_value_reg;
  assign bus.im_pos     = im_pos_reg;
  assign bus.smp_clr    = smp_clr_reg;
  assign bus.label      = label_reg;
  assign bus.set_clr    = set_clr_reg;
  assign bus.pred_valid = pred_valid_reg;
  assign bus.err_len    = err_len_reg;

endmodule

// File: tb/tb_hd_sample_feeder.sv
// tb_hd_sample_feeder
//   Scoreboard bench for hd_sample_feeder (DIM=16, LVL_NUM=4, FEAT_MAX=4).
//   Each accepted beat pushes its expected im_value/im_pos; a negedge monitor
//   pops one entry per smp_en pulse. Scenario tasks check framing inline.
module tb_hd_sample_feeder;
  localparam int DIM      = 16;
  localparam int VAL_W    = 8;
  localparam int LVL_NUM  = 4;
  localparam int FEAT_MAX = 4;
  localparam int CLS_DW   = 4;
  localparam int PRED_LAT = 2;
  localparam logic TRAIN   = 1'b0;
  localparam logic PREDICT = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hd_sample_feeder_if #(.DIM(DIM), .VAL_W(VAL_W), .CLS_DW(CLS_DW)) bus ();

  hd_sample_feeder #(
    .DIM(DIM), .VAL_W(VAL_W), .LVL_NUM(LVL_NUM), .FEAT_MAX(FEAT_MAX),
    .CLS_DW(CLS_DW), .PRED_LAT(PRED_LAT),
    .POS_SEED(16'h0001), .LVL_SEED(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [DIM-1:0] value;
    logic [DIM-1:0] pos;
  } beat_exp_t;

  beat_exp_t sb_q[$];
  beat_exp_t mon_exp;
  int vectors = 0;
  int miscompares = 0;
  int beat_idx = 0;

  // Reference level vector: level = value/64, 4 bits flipped per level.
  function automatic logic [DIM-1:0] exp_level(input logic [VAL_W-1:0] v);
    int lvl;
    logic [31:0] m;
    lvl = int'(v) / 64;
    m = (32'd1 << (lvl * (DIM / LVL_NUM))) - 32'd1;
    return m[DIM-1:0];
  endfunction

  // Scoreboard monitor: every smp_en pulse must match the oldest accepted beat.
  always @(negedge clk) begin
    if (bus.smp_en === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL smp_en_spurious: smp_en=1 with no accepted beat pending (required 0)");
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.im_value !== mon_exp.value || bus.im_pos !== mon_exp.pos) begin
          miscompares++;
          $display("FAIL beat: im_value=%h im_pos=%h, required im_value=%h im_pos=%h",
                   bus.im_value, bus.im_pos, mon_exp.value, mon_exp.pos);
        end else begin
          $display("beat     im_value=%h im_pos=%h", bus.im_value, bus.im_pos);
        end
      end
    end
  end

  // Present one beat and hold it until accepted; pushes the expectation.
  task automatic send_beat(input logic [VAL_W-1:0] v, input logic last, input logic mode,
                           input logic [CLS_DW-1:0] lbl, input logic setlast);
    bit done;
    beat_exp_t e;
    done = 1'b0;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_value   = v;
    bus.in_last    = last;
    bus.in_mode    = mode;
    bus.in_label   = lbl;
    bus.in_setlast = setlast;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed %b for 20 cycles (required 1)", bus.in_ready);
    end else begin
      e.value = exp_level(v);
      e.pos   = DIM'(1) << beat_idx;
      sb_q.push_back(e);
      beat_idx++;
      if (last || beat_idx == FEAT_MAX) beat_idx = 0;
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.smp_en, bus.smp_clr, bus.set_clr, bus.pred_valid, bus.err_len, bus.state, bus.in_ready} !== 7'b0000001) begin
      miscompares++;
      $display("FAIL reset_ctrl: {smp_en,smp_clr,set_clr,pred_valid,err_len,state,in_ready}=%b required 0000001",
               {bus.smp_en, bus.smp_clr, bus.set_clr, bus.pred_valid, bus.err_len, bus.state, bus.in_ready});
    end
    vectors++;
    if (bus.im_value !== 16'h0000 || bus.im_pos !== 16'h0000 || bus.label !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: im_value=%h im_pos=%h label=%0d required 0000 0000 0",
               bus.im_value, bus.im_pos, bus.label);
    end
    rst_n = 1'b1;
    beat_idx = 0;
    $display("reset    done");
  endtask

  // T1: train, no setlast
  task automatic test_train();
    send_beat(8'h00, 1'b0, TRAIN, 4'd2, 1'b0);
    send_beat(8'h40, 1'b0, TRAIN, 4'd2, 1'b0);
    send_beat(8'hC0, 1'b1, TRAIN, 4'd2, 1'b0);
    next_cycle();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.smp_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL train_close: in_ready=%b smp_clr=%b required 0 0", bus.in_ready, bus.smp_clr);
    end
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.label !== 4'd2 || bus.state !== TRAIN || bus.set_clr !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL train_clr: smp_clr=%b label=%0d state=%b set_clr=%b in_ready=%b required 1 2 0 0 1",
               bus.smp_clr, bus.label, bus.state, bus.set_clr, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b0 || bus.set_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL train_after: smp_clr=%b set_clr=%b required 0 0", bus.smp_clr, bus.set_clr);
    end
    $display("sample   train label=2 closed");
  endtask

  // T2: train, set closes
  task automatic test_set_clr();
    send_beat(8'h00, 1'b0, TRAIN, 4'd2, 1'b0);
    send_beat(8'h40, 1'b0, TRAIN, 4'd2, 1'b0);
    send_beat(8'hC0, 1'b1, TRAIN, 4'd2, 1'b1);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.set_clr !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL setclr_t0: smp_clr=%b set_clr=%b in_ready=%b required 1 0 0", bus.smp_clr, bus.set_clr, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b0 || bus.set_clr !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL setclr_t1: smp_clr=%b set_clr=%b in_ready=%b required 0 1 0", bus.smp_clr, bus.set_clr, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.set_clr !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL setclr_t2: set_clr=%b in_ready=%b required 0 1", bus.set_clr, bus.in_ready);
    end
    $display("sample   train set closed");
  endtask

  // T3: predict
  task automatic test_predict();
    send_beat(8'h80, 1'b0, PREDICT, 4'd3, 1'b0);
    send_beat(8'hFF, 1'b1, PREDICT, 4'd3, 1'b0);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.label !== 4'd0 || bus.state !== PREDICT || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pred_clr: smp_clr=%b label=%0d state=%b in_ready=%b required 1 0 1 0",
               bus.smp_clr, bus.label, bus.state, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.pred_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pred_t1: pred_valid=%b in_ready=%b required 0 0", bus.pred_valid, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.pred_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pred_t2: pred_valid=%b in_ready=%b required 1 0", bus.pred_valid, bus.in_ready);
    end
    next_cycle();
    vectors++;
    if (bus.pred_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pred_t3: pred_valid=%b in_ready=%b required 0 1", bus.pred_valid, bus.in_ready);
    end
    $display("sample   predict done");
  endtask

  // T6: gaps in in_valid, mode flipped on a non-first beat
  task automatic test_gap();
    send_beat(8'h10, 1'b0, TRAIN, 4'd1, 1'b0);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_en !== 1'b0 || bus.im_pos !== 16'h0001 || bus.im_value !== 16'h0000) begin
      miscompares++;
      $display("FAIL gap_hold: smp_en=%b im_pos=%h im_value=%h required 0 0001 0000",
               bus.smp_en, bus.im_pos, bus.im_value);
    end
    send_beat(8'hC0, 1'b1, PREDICT, 4'd5, 1'b0);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.state !== TRAIN || bus.label !== 4'd1 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_clr: smp_clr=%b state=%b label=%0d in_ready=%b required 1 0 1 1",
               bus.smp_clr, bus.state, bus.label, bus.in_ready);
    end
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.pred_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_nopred: pred_valid=%b required 0", bus.pred_valid);
    end
    $display("sample   gapped train done");
  endtask

  // T4: forced close at FEAT_MAX, then a single-beat sample
  task automatic test_overflow();
    vectors++;
    if (bus.err_len !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pre: err_len=%b required 0", bus.err_len);
    end
    send_beat(8'h00, 1'b0, TRAIN, 4'd4, 1'b0);
    send_beat(8'h40, 1'b0, TRAIN, 4'd4, 1'b0);
    send_beat(8'h80, 1'b0, TRAIN, 4'd4, 1'b0);
    send_beat(8'hC0, 1'b0, TRAIN, 4'd4, 1'b0);
    next_cycle();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.err_len !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_close: in_ready=%b err_len=%b required 0 1", bus.in_ready, bus.err_len);
    end
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_clr: smp_clr=%b required 1", bus.smp_clr);
    end
    send_beat(8'hFF, 1'b1, TRAIN, 4'd6, 1'b0);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.err_len !== 1'b1 || bus.label !== 4'd6) begin
      miscompares++;
      $display("FAIL single_clr: smp_clr=%b err_len=%b label=%0d required 1 1 6", bus.smp_clr, bus.err_len, bus.label);
    end
    $display("sample   overflow + single beat done");
  endtask

  // T5: reset in the middle of a sample
  task automatic test_reset_mid();
    send_beat(8'h40, 1'b0, TRAIN, 4'd3, 1'b0);
    send_beat(8'h80, 1'b0, TRAIN, 4'd3, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    beat_idx = 0;
    @(negedge clk);
    vectors++;
    if (bus.smp_clr !== 1'b0 || bus.smp_en !== 1'b0 || bus.im_pos !== 16'h0000 || bus.im_value !== 16'h0000 || bus.err_len !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: smp_clr=%b smp_en=%b im_pos=%h im_value=%h err_len=%b required 0 0 0000 0000 0",
               bus.smp_clr, bus.smp_en, bus.im_pos, bus.im_value, bus.err_len);
    end
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_noclr: smp_clr=%b required 0", bus.smp_clr);
    end
    send_beat(8'hC0, 1'b1, TRAIN, 4'd7, 1'b0);
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.smp_clr !== 1'b1 || bus.label !== 4'd7) begin
      miscompares++;
      $display("FAIL midreset_next: smp_clr=%b label=%0d required 1 7", bus.smp_clr, bus.label);
    end
    next_cycle();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected beats never appeared (required 0)", sb_q.size());
    end
    $display("sample   reset mid-sample done");
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_value   = '0;
    bus.in_last    = 1'b0;
    bus.in_mode    = TRAIN;
    bus.in_label   = '0;
    bus.in_setlast = 1'b0;
    test_reset();
    test_train();
    test_set_clr();
    test_predict();
    test_gap();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
